// File: rtl/noc_tx_framer.sv
// Byte-wide request framer for the NOC port wrapper: serializes read/write requests
// onto the wrapper's "to" interface, launching a write only once its payload is buffered.
module noc_tx_framer #(
  parameter int         FIFO_DEPTH = 16,
  parameter int         ADDR_BYTES = 4,
  parameter logic [7:0] SRC_ID     = 8'h01
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_op,
  input  logic [7:0]              req_dest,
  input  logic [8*ADDR_BYTES-1:0] req_addr,
  input  logic [4:0]              req_len,
  input  logic                    wr_data_valid,
  output logic                    wr_data_ready,
  input  logic [7:0]              wr_data,
  output logic                    noc_to_dev_ctl,
  output logic [7:0]              noc_to_dev_data,
  output logic                    busy,
  output logic                    err_pulse
);

  localparam int              PW        = $clog2(FIFO_DEPTH);
  localparam int              CW        = $clog2(FIFO_DEPTH + 1);
  localparam logic [PW-1:0]   PTR_LAST  = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0]   DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [4:0]      ADDR_LAST = 5'(ADDR_BYTES - 1);

  typedef enum logic [2:0] {IDLE, HDR, DEST, SRC, ADDR, DATA, GAP} state_t;

  state_t                  state, state_next;
  logic [7:0]              mem [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           fifo_count, count_next;
  logic                    op_q;
  logic [7:0]              dest_q;
  logic [8*ADDR_BYTES-1:0] addr_q, addr_shift;
  logic [4:0]              len_q, cnt;
  logic                    len_bad, accept, push, pop;
  logic                    ctl_next;
  logic [7:0]              data_next;

  // busy covers the whole wire span through GAP, so it also blocks acceptance there
  assign len_bad    = (req_len == 5'd0) || (req_len > 5'd16);
  assign req_ready  = (state == IDLE) && !busy && !reset &&
                      (!req_op || (fifo_count >= CW'(req_len)) || len_bad);
  assign accept     = req_valid && req_ready;
  assign push       = wr_data_valid && wr_data_ready;
  assign pop        = (state == DATA);
  assign count_next = fifo_count + CW'(push) - CW'(pop);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && !len_bad) state_next = HDR;
      HDR:     state_next = DEST;
      DEST:    state_next = SRC;
      SRC:     state_next = ADDR;
      ADDR:    if (cnt == ADDR_LAST) state_next = op_q ? DATA : GAP;
      DATA:    if (cnt == len_q - 5'd1) state_next = GAP;
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Byte for the wire; registered below so the wire trails the state by one cycle
  always_comb begin
    ctl_next   = 1'b1;
    data_next  = 8'h00;
    addr_shift = addr_q >> {cnt, 3'b000};
    case (state)
      HDR:  data_next = {(op_q ? 3'b010 : 3'b001), len_q - 5'd1};
      DEST: begin ctl_next = 1'b0; data_next = dest_q; end
      SRC:  begin ctl_next = 1'b0; data_next = SRC_ID; end
      ADDR: begin ctl_next = 1'b0; data_next = addr_shift[7:0]; end
      DATA: begin ctl_next = 1'b0; data_next = mem[rd_ptr]; end
      default: begin ctl_next = 1'b1; data_next = 8'h00; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= 5'd0;
      op_q            <= 1'b0;
      dest_q          <= 8'h00;
      addr_q          <= '0;
      len_q           <= 5'd0;
      noc_to_dev_ctl  <= 1'b1;
      noc_to_dev_data <= 8'h00;
      busy            <= 1'b0;
      err_pulse       <= 1'b0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_count      <= '0;
      wr_data_ready   <= 1'b1;
    end else begin
      state           <= state_next;
      cnt             <= (state_next != state) ? 5'd0 : cnt + 5'd1;
      if (accept) begin
        op_q   <= req_op;
        dest_q <= req_dest;
        addr_q <= req_addr;
        len_q  <= req_len;
      end
      noc_to_dev_ctl  <= ctl_next;
      noc_to_dev_data <= data_next;
      busy            <= (state != IDLE);
      err_pulse       <= accept && len_bad;
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      fifo_count      <= count_next;
      wr_data_ready   <= (count_next < DEPTH_C);
    end
  end

  // Payload storage needs no reset; pointers and count define what is valid
  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_noc_tx_framer.sv
// Directed bench for noc_tx_framer: drives requests and payload on the falling edge
// and compares every wire byte against hand-computed packet contents.
module tb_noc_tx_framer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid, req_ready, req_op;
  logic [7:0]  req_dest;
  logic [31:0] req_addr;
  logic [4:0]  req_len;
  logic        wr_data_valid, wr_data_ready;
  logic [7:0]  wr_data;
  logic        noc_to_dev_ctl;
  logic [7:0]  noc_to_dev_data;
  logic        busy, err_pulse;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  exp_q[$];

  noc_tx_framer dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_dest(req_dest), .req_addr(req_addr), .req_len(req_len),
    .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready), .wr_data(wr_data),
    .noc_to_dev_ctl(noc_to_dev_ctl), .noc_to_dev_data(noc_to_dev_data),
    .busy(busy), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr_data       = b;
    wr_data_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wr_data_valid = 1'b0;
  endtask

  task automatic send_req(input logic op, input logic [7:0] dest, input logic [31:0] addr,
                          input logic [4:0] len);
    req_op    = op;
    req_dest  = dest;
    req_addr  = addr;
    req_len   = len;
    req_valid = 1'b1;
    for (int n = 0; n < 40 && !req_ready; n++) @(negedge clk);
    check("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = 1'b0;
    req_dest  = 8'hFF;
    req_addr  = 32'hFFFF_FFFF;
    req_len   = 5'd9;
  endtask

  // Called on the falling edge right after acceptance; walks the packet in exp_q
  task automatic check_wire(input string tag);
    check({tag, "_latency_idle"}, {23'd0, noc_to_dev_ctl, noc_to_dev_data}, 32'h100);
    foreach (exp_q[i]) begin
      @(negedge clk);
      check($sformatf("%s_byte%0d", tag, i), {23'd0, noc_to_dev_ctl, noc_to_dev_data},
            {23'd0, (i == 0) ? 1'b1 : 1'b0, exp_q[i]});
      check($sformatf("%s_busy%0d", tag, i), {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    check({tag, "_gap"}, {23'd0, noc_to_dev_ctl, noc_to_dev_data}, 32'h100);
    check({tag, "_gap_busy"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    check({tag, "_after_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    req_valid = 1'b0; req_op = 1'b0; req_dest = 8'h00; req_addr = 32'h0; req_len = 5'd1;
    wr_data_valid = 1'b0; wr_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_wire", {23'd0, noc_to_dev_ctl, noc_to_dev_data}, 32'h100);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_wire", {23'd0, noc_to_dev_ctl, noc_to_dev_data}, 32'h100);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_wr_ready", {31'd0, wr_data_ready}, 32'd1);
      check("idle_err", {31'd0, err_pulse}, 32'd0);
    end
    check("idle_fifo_count", 32'(dut.fifo_count), 32'd0);

    // Read, len 4
    send_req(1'b0, 8'h05, 32'h1234_5678, 5'd4);
    exp_q = '{8'h23, 8'h05, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12};
    check_wire("rd4");
    check("rd4_ready_again", {31'd0, req_ready}, 32'd1);

    // Write, len 3, payload preloaded
    push_byte(8'hAA); push_byte(8'hBB); push_byte(8'hCC);
    check("wr3_fifo_loaded", 32'(dut.fifo_count), 32'd3);
    send_req(1'b1, 8'h07, 32'hA0B1_C2D3, 5'd3);
    exp_q = '{8'h42, 8'h07, 8'h01, 8'hD3, 8'hC2, 8'hB1, 8'hA0, 8'hAA, 8'hBB, 8'hCC};
    check_wire("wr3");
    check("wr3_fifo_drained", 32'(dut.fifo_count), 32'd0);

    // Write, len 16, held off until the 16th byte arrives
    for (int i = 0; i < 15; i++) push_byte(8'h10 + 8'(i));
    req_op = 1'b1; req_dest = 8'h09; req_addr = 32'h0000_0100; req_len = 5'd16; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("wr16_held", {31'd0, req_ready}, 32'd0);
    end
    wr_data = 8'h1F; wr_data_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wr_data_valid = 1'b0;
    check("wr16_full_count", 32'(dut.fifo_count), 32'd16);
    check("wr16_full_wr_ready", {31'd0, wr_data_ready}, 32'd0);
    check("wr16_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_dest = 8'hFF; req_addr = 32'hFFFF_FFFF;
    exp_q = '{8'h4F, 8'h09, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00};
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h10 + 8'(i));
    check_wire("wr16");
    check("wr16_wr_ready_back", {31'd0, wr_data_ready}, 32'd1);
    check("wr16_fifo_empty", 32'(dut.fifo_count), 32'd0);

    // One leftover byte that must survive illegal requests and a read
    push_byte(8'h99);
    check("leftover_count", 32'(dut.fifo_count), 32'd1);

    // Illegal lengths 0 and 17
    send_req(1'b0, 8'h01, 32'h0, 5'd0);
    check("len0_err", {31'd0, err_pulse}, 32'd1);
    check("len0_wire", {23'd0, noc_to_dev_ctl, noc_to_dev_data}, 32'h100);
    @(negedge clk);
    check("len0_err_clear", {31'd0, err_pulse}, 32'd0);
    check("len0_wire2", {23'd0, noc_to_dev_ctl, noc_to_dev_data}, 32'h100);
    check("len0_busy", {31'd0, busy}, 32'd0);
    send_req(1'b1, 8'h01, 32'h0, 5'd17);
    check("len17_err", {31'd0, err_pulse}, 32'd1);
    @(negedge clk);
    check("len17_err_clear", {31'd0, err_pulse}, 32'd0);
    check("len17_wire", {23'd0, noc_to_dev_ctl, noc_to_dev_data}, 32'h100);
    check("len17_fifo_untouched", 32'(dut.fifo_count), 32'd1);

    // Legal read after the errors
    send_req(1'b0, 8'h3C, 32'hDEAD_BEEF, 5'd16);
    exp_q = '{8'h2F, 8'h3C, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    check_wire("rd16");
    check("rd16_no_pop", 32'(dut.fifo_count), 32'd1);

    // Write len 1 consumes the leftover byte
    send_req(1'b1, 8'h11, 32'h0, 5'd1);
    exp_q = '{8'h40, 8'h11, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h99};
    check_wire("wr1");
    check("wr1_fifo_empty", 32'(dut.fifo_count), 32'd0);

    // Reset while address byte 2 of a write is on the wire
    push_byte(8'h55); push_byte(8'h66);
    send_req(1'b1, 8'h22, 32'h0403_0201, 5'd2);
    exp_q = '{8'h41, 8'h22, 8'h01, 8'h01, 8'h02};
    foreach (exp_q[i]) begin
      @(negedge clk);
      check($sformatf("rstmid_byte%0d", i), {23'd0, noc_to_dev_ctl, noc_to_dev_data},
            {23'd0, (i == 0) ? 1'b1 : 1'b0, exp_q[i]});
    end
    reset = 1'b1; wr_data = 8'h77; wr_data_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rstmid_wire", {23'd0, noc_to_dev_ctl, noc_to_dev_data}, 32'h100);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_fifo", 32'(dut.fifo_count), 32'd0);
    check("rstmid_req_ready", {31'd0, req_ready}, 32'd0);
    reset = 1'b0; wr_data_valid = 1'b0;
    @(negedge clk);
    check("rstmid_push_ignored", 32'(dut.fifo_count), 32'd0);
    check("rstmid_wr_ready", {31'd0, wr_data_ready}, 32'd1);
    check("rstmid_wire2", {23'd0, noc_to_dev_ctl, noc_to_dev_data}, 32'h100);

    // Fresh read after the reset
    send_req(1'b0, 8'h44, 32'h0A0B_0C0D, 5'd1);
    exp_q = '{8'h20, 8'h44, 8'h01, 8'h0D, 8'h0C, 8'h0B, 8'h0A};
    check_wire("rd_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
